// File: rtl/mac_dec_rr_if.sv
// mac_dec_rr_if: PHY, header and body FIFO signal bundle for the round-robin frame decoder
interface mac_dec_rr_if #(
  parameter int N_PORTS = 4,
  parameter int HDR_BYTES = 14,
  parameter int LEN_W = 11,
  parameter int PID_W = ($clog2(N_PORTS) > 1) ? $clog2(N_PORTS) : 1,
  parameter int HW = 8*HDR_BYTES + LEN_W + PID_W + 1
);
  logic [8*N_PORTS-1:0] i_fifo_dout;
  logic [N_PORTS-1:0] i_fifo_empty;
  logic [N_PORTS-1:0] i_fifo_aempty;
  logic [N_PORTS-1:0] i_fifo_del;
  logic [N_PORTS-1:0] i_fifo_rden;
  logic [HW-1:0] h_fifo_din;
  logic h_fifo_full;
  logic h_fifo_wren;
  logic [7:0] b_fifo_din;
  logic b_fifo_afull;
  logic b_fifo_wren;
  logic b_fifo_del;
  modport master (
    input i_fifo_dout, i_fifo_empty, i_fifo_aempty, i_fifo_del, h_fifo_full, b_fifo_afull,
    output i_fifo_rden, h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, b_fifo_del
  );
  modport slave (
    output i_fifo_dout, i_fifo_empty, i_fifo_aempty, i_fifo_del, h_fifo_full, b_fifo_afull,
    input i_fifo_rden, h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, b_fifo_del
  );
endinterface

// File: rtl/mac_dec_rr.sv
// mac_dec_rr: round-robin PHY FIFO frame decoder splitting frames into header descriptors and payload bytes
module mac_dec_rr #(
  parameter int N_PORTS = 4,
  parameter int HDR_BYTES = 14,
  parameter int MAX_FRAME = 1514,
  parameter int LEN_W = 11
) (
  input logic clk,
  input logic arst,
  mac_dec_rr_if.master m,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_runts,
  output logic [15:0] stat_oversize
);
  localparam int PID_W = ($clog2(N_PORTS) > 1) ? $clog2(N_PORTS) : 1;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DRAIN, END} state_t;
  state_t state, state_nx;
  logic [PID_W-1:0] ptr, port_id, gnt_id, idx;
  logic [LEN_W-1:0] length;
  logic [8*HDR_BYTES-1:0] hdr;
  logic err, gnt_ok, grant, pop, head_del, over, body_wr;
  logic [7:0] head;
  always_comb begin
    gnt_id = ptr;
    gnt_ok = 1'b0;
    idx = '0;
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = PID_W'((int'(ptr) + i) % N_PORTS);
      if (!m.i_fifo_aempty[idx]) begin
        gnt_ok = 1'b1;
        gnt_id = idx;
      end
    end
  end
  always_comb begin
    grant = state == IDLE && gnt_ok && !m.h_fifo_full && !m.b_fifo_afull;
    head = 8'(m.i_fifo_dout >> {port_id, 3'b000});
    head_del = m.i_fifo_del[port_id];
    pop = (state == HEADER || state == PAYLOAD || state == DRAIN) && !m.i_fifo_empty[port_id];
    over = length >= LEN_W'(MAX_FRAME);
    body_wr = pop && !head_del && state == PAYLOAD && !over;
    m.i_fifo_rden = pop ? N_PORTS'(1) << port_id : '0;
    m.h_fifo_wren = state == END;
    m.b_fifo_del = state == END;
    m.h_fifo_din = state == END ? {err, port_id, length, hdr} : '0;
    state_nx = state;
    case (state)
      IDLE: state_nx = grant ? HEADER : IDLE;
      HEADER: state_nx = !pop ? HEADER : head_del ? IDLE : length == LEN_W'(HDR_BYTES-1) ? PAYLOAD : HEADER;
      PAYLOAD: state_nx = !pop ? PAYLOAD : head_del ? END : over ? DRAIN : PAYLOAD;
      DRAIN: state_nx = pop && head_del ? END : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr <= PID_W'(N_PORTS-1);
      port_id <= '0;
      length <= '0;
      hdr <= '0;
      err <= 1'b0;
      m.b_fifo_din <= '0;
      m.b_fifo_wren <= 1'b0;
      stat_frames <= '0;
      stat_runts <= '0;
      stat_oversize <= '0;
    end else begin
      m.b_fifo_wren <= body_wr;
      if (body_wr) m.b_fifo_din <= head;
      if (grant) begin
        port_id <= gnt_id;
        ptr <= gnt_id;
        length <= '0;
        err <= 1'b0;
      end
      if (pop && !head_del) begin
        length <= &length ? length : length + 1'b1;
        if (state == HEADER) hdr <= {hdr[8*HDR_BYTES-9:0], head};
        if (state == PAYLOAD && over) begin
          err <= 1'b1;
          stat_oversize <= stat_oversize + {15'd0, ~&stat_oversize};
        end
      end
      if (state == HEADER && pop && head_del) stat_runts <= stat_runts + {15'd0, ~&stat_runts};
      if (state == END) stat_frames <= stat_frames + {15'd0, ~&stat_frames};
    end
  end
endmodule

// File: tb/tb_mac_dec_rr.sv
// tb_mac_dec_rr: scoreboard bench for the round-robin frame decoder
module tb_mac_dec_rr;
  localparam int NP = 4;
  localparam int HB = 14;
  localparam int MF = 1514;
  localparam int LW = 11;
  localparam int PW = 2;
  localparam int HW = 8*HB + LW + PW + 1;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [15:0] st_fr, st_ru, st_ov;
  mac_dec_rr_if #(.N_PORTS(NP), .HDR_BYTES(HB), .LEN_W(LW)) bus();
  mac_dec_rr #(.N_PORTS(NP), .HDR_BYTES(HB), .MAX_FRAME(MF), .LEN_W(LW)) dut (
    .clk(clk),
    .arst(arst),
    .m(bus),
    .stat_frames(st_fr),
    .stat_runts(st_ru),
    .stat_oversize(st_ov)
  );
  always #5 clk = ~clk;
  logic [8:0] mem [NP][4096];
  int hd [NP];
  int tl [NP];
  int pops [NP];
  logic [HW-1:0] exp_h [$];
  logic [7:0] exp_b [$];
  int n_vec = 0;
  int n_err = 0;
  int n_body = 0;
  int e_fr = 0;
  int e_ru = 0;
  int e_ov = 0;
  bit toggle = 1'b0;
  bit phase = 1'b0;
  bit has_d;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic load(input int p, input int len, input int seed);
    logic [8*HB-1:0] h = '0;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'(seed + i*7 + (i >> 3));
      mem[p][tl[p]] = {1'b0, b};
      tl[p]++;
      if (i < HB) h = {h[8*HB-9:0], b};
      else if (i < MF) exp_b.push_back(b);
    end
    mem[p][tl[p]] = 9'h100;
    tl[p]++;
    if (len < HB) e_ru++;
    else begin
      exp_h.push_back({len > MF ? 1'b1 : 1'b0, PW'(p), LW'(len > 2047 ? 2047 : len), h});
      e_fr++;
      if (len > MF) e_ov++;
    end
  endtask
  task automatic monitor();
    logic [NP-1:0] r;
    r = bus.i_fifo_rden;
    if (r != '0) begin
      chk("rden_onehot", 128'($onehot(r)), 1);
      chk("rden_while_empty", 128'(|(r & bus.i_fifo_empty)), 0);
      for (int p = 0; p < NP; p++)
        if (r[p]) begin
          pops[p]++;
          if (hd[p] < tl[p]) hd[p]++;
        end
    end
    if (bus.h_fifo_wren) begin
      if (exp_h.size() == 0) chk("hdr_unexpected", 128'(exp_h.size()), 1);
      else chk("hdr", 128'(bus.h_fifo_din), 128'(exp_h.pop_front()));
      chk("del_with_hdr", 128'(bus.b_fifo_del), 1);
    end else if (bus.b_fifo_del) chk("del_without_hdr", 128'(bus.h_fifo_wren), 1);
    if (bus.b_fifo_del) chk("wren_with_del", 128'(bus.b_fifo_wren), 0);
    if (bus.b_fifo_wren) begin
      n_body++;
      if (exp_b.size() == 0) chk("body_unexpected", 128'(exp_b.size()), 1);
      else chk("body", 128'(bus.b_fifo_din), 128'(exp_b.pop_front()));
    end
  endtask
  initial forever begin
    @(negedge clk);
    phase = ~phase;
    for (int p = 0; p < NP; p++) begin
      has_d = hd[p] < tl[p];
      bus.i_fifo_empty[p] = !has_d || (toggle && phase);
      bus.i_fifo_aempty[p] = !has_d;
      {bus.i_fifo_del[p], bus.i_fifo_dout[8*p +: 8]} = has_d ? mem[p][hd[p]] : 9'h0;
    end
    #3;
    monitor();
  end
  task automatic wait_done(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #4;
      done = exp_h.size() == 0 && exp_b.size() == 0;
      for (int p = 0; p < NP; p++) if (hd[p] != tl[p]) done = 1'b0;
    end
    chk({"done_", tag}, 128'(done), 1);
    repeat (3) @(negedge clk);
    #4;
  endtask
  initial begin
    bus.i_fifo_dout = '0;
    bus.i_fifo_empty = '1;
    bus.i_fifo_aempty = '1;
    bus.i_fifo_del = '0;
    bus.h_fifo_full = 1'b0;
    bus.b_fifo_afull = 1'b0;
    for (int p = 0; p < NP; p++) begin
      hd[p] = 0;
      tl[p] = 0;
      pops[p] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_frames", 128'(st_fr), 0);
    chk("rst_runts", 128'(st_ru), 0);
    chk("rst_oversize", 128'(st_ov), 0);
    chk("rst_hwren", 128'(bus.h_fifo_wren), 0);
    chk("rst_hdin", 128'(bus.h_fifo_din), 0);
    chk("rst_bwren", 128'(bus.b_fifo_wren), 0);
    chk("rst_bdel", 128'(bus.b_fifo_del), 0);
    chk("rst_rden", 128'(bus.i_fifo_rden), 0);
    arst = 1'b0;
    @(negedge clk);
    #4;
    load(2, 60, 16);
    wait_done("single", 300);
    chk("single_frames", 128'(st_fr), 128'(e_fr));
    chk("single_body", 128'(n_body), 46);
    chk("single_pops", 128'(pops[2]), 61);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < NP; j++) load((j + 3) % NP, 20 + 10*k + (j + 3) % NP, 40*j + 100*k);
    wait_done("rr", 1500);
    chk("rr_frames", 128'(st_fr), 128'(e_fr));
    pops[1] = 0;
    n_body = 0;
    load(1, 9, 5);
    wait_done("runt", 200);
    chk("runt_pops", 128'(pops[1]), 10);
    chk("runt_count", 128'(st_ru), 128'(e_ru));
    chk("runt_body", 128'(n_body), 0);
    chk("runt_frames", 128'(st_fr), 128'(e_fr));
    pops[0] = 0;
    n_body = 0;
    load(0, 1600, 3);
    wait_done("oversize", 2500);
    chk("over_body", 128'(n_body), 1500);
    chk("over_count", 128'(st_ov), 128'(e_ov));
    chk("over_pops", 128'(pops[0]), 1601);
    chk("over_frames", 128'(st_fr), 128'(e_fr));
    n_body = 0;
    load(3, HB, 77);
    wait_done("hdr_only", 200);
    chk("hdr_only_body", 128'(n_body), 0);
    chk("hdr_only_frames", 128'(st_fr), 128'(e_fr));
    n_body = 0;
    load(1, MF, 9);
    wait_done("max_frame", 2500);
    chk("max_body", 128'(n_body), 1500);
    chk("max_oversize", 128'(st_ov), 128'(e_ov));
    bus.b_fifo_afull = 1'b1;
    toggle = 1'b1;
    pops[0] = 0;
    load(0, 30, 200);
    repeat (20) @(negedge clk);
    #4;
    chk("afull_no_grant", 128'(pops[0]), 0);
    bus.b_fifo_afull = 1'b0;
    wait_done("toggle", 400);
    chk("toggle_pops", 128'(pops[0]), 31);
    chk("toggle_frames", 128'(st_fr), 128'(e_fr));
    toggle = 1'b0;
    n_body = 0;
    load(3, 40, 55);
    for (int c = 0; c < 200 && n_body < 5; c++) begin
      @(negedge clk);
      #4;
    end
    chk("abort_started", 128'(n_body >= 5), 1);
    @(negedge clk);
    #1;
    arst = 1'b1;
    #1;
    chk("abort_rden", 128'(bus.i_fifo_rden), 0);
    chk("abort_bwren", 128'(bus.b_fifo_wren), 0);
    chk("abort_bdin", 128'(bus.b_fifo_din), 0);
    chk("abort_hwren", 128'(bus.h_fifo_wren), 0);
    chk("abort_frames", 128'(st_fr), 0);
    chk("abort_oversize", 128'(st_ov), 0);
    hd[3] = tl[3];
    exp_h.delete();
    exp_b.delete();
    e_fr = 0;
    e_ru = 0;
    e_ov = 0;
    @(negedge clk);
    #1;
    arst = 1'b0;
    load(0, 22, 61);
    load(1, 20, 62);
    wait_done("post_reset", 400);
    chk("post_reset_frames", 128'(st_fr), 128'(e_fr));
    chk("post_reset_runts", 128'(st_ru), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mac_dec_rr.md
Name: mac_dec_rr

Overview:
Parametrised successor of the PHY-FIFO frame decoder. Arbitrates round-robin over N_PORTS first-word-fall-through PHY FIFOs and splits each frame into a header descriptor (header bytes, source port, frame length, error flag) written to the header FIFO, and payload bytes written to the body FIFO. Detects runt and oversize frames and keeps saturating statistics. Sits between the PHY RX FIFOs and the switch lookup/forwarding stage.

Parameters:
N_PORTS, 4, number of PHY input FIFOs (2..16).
HDR_BYTES, 14, header bytes captured per frame.
MAX_FRAME, 1514, maximum legal frame length in bytes, header included.
LEN_W, 11, frame-length field width; must satisfy 2^LEN_W-1 >= MAX_FRAME.
Derived: PID_W = max(1, clog2(N_PORTS)); HW = 8*HDR_BYTES + LEN_W + PID_W + 1.

Ports:
clk  in  1  clock.
arst  in  1  asynchronous reset, active-high.
i_fifo_dout  in  8*N_PORTS  head byte of each PHY FIFO; port p at [8p+7:8p].
i_fifo_empty  in  N_PORTS  per-port empty.
i_fifo_aempty  in  N_PORTS  per-port almost-empty.
i_fifo_del  in  N_PORTS  head entry of port p is a frame delimiter, not data.
i_fifo_rden  out  N_PORTS  pop head entry of port p.
h_fifo_din  out  HW  {err, port_id, length, header}; header byte 0 in the MSBs.
h_fifo_full  in  1  header FIFO full.
h_fifo_wren  out  1  header write strobe.
b_fifo_din  out  8  payload byte.
b_fifo_afull  in  1  body FIFO has less than MAX_FRAME bytes free.
b_fifo_wren  out  1  payload write strobe.
b_fifo_del  out  1  end-of-frame pulse to the body FIFO.
stat_frames  out  16  frames completed (good and oversize), saturating.
stat_runts  out  16  runt frames dropped, saturating.
stat_oversize  out  16  oversize frames, saturating.

Behaviour:
- Reset: state IDLE, all outputs 0, counters 0, round-robin pointer = N_PORTS-1 so that port 0 is searched first. Reset mid-frame abandons the frame. No partial header is written. Bytes already in the body FIFO are left there.
- Eligible port: ~i_fifo_aempty[p].
- IDLE: grant only when ~h_fifo_full & ~b_fifo_afull. Grant the first eligible port after the pointer, in ascending order with wrap-around. Latch port_id and set pointer = port_id. Clear the length count and err, then go to HEADER. If no port is eligible, stay in IDLE.
- Consume: in HEADER, PAYLOAD or DRAIN, the head entry of the selected port is popped when ~i_fifo_empty[sel]. i_fifo_rden[sel] is combinational and high in the same cycle. All other rden bits stay 0 at all times. When the FIFO is empty, the block stalls with no pop.
- HEADER: each data byte is shifted into the header register and increments length. After HDR_BYTES bytes, go to PAYLOAD.
- Runt: a delimiter popped in HEADER marks a runt. Increment stat_runts and go to IDLE. No h_fifo_wren, no b_fifo_del.
- PAYLOAD: each data byte is registered to b_fifo_din with b_fifo_wren high 1 cycle later, and increments length.
  - When length would exceed MAX_FRAME, the byte is not written. err is set, stat_oversize is incremented once per frame, and the state goes to DRAIN.
- DRAIN: pop and discard data bytes. length keeps counting and saturates at 2^LEN_W-1.
- Delimiter popped in PAYLOAD or DRAIN: go to END.
- END, 1 cycle: h_fifo_wren=1 with h_fifo_din={err, port_id, length, header} and b_fifo_del=1 in the same cycle. Increment stat_frames, then go to IDLE. A frame of exactly HDR_BYTES writes a header and b_fifo_del with no body bytes.
- The last payload b_fifo_wren precedes b_fifo_del by at least 1 cycle.
- h_fifo_full and b_fifo_afull are sampled only in IDLE. Space is guaranteed for the granted frame.
- Statistics counters saturate at 16'hFFFF.
- Back-to-back frames: minimum 1 IDLE cycle between END and the next HEADER.

Test Plan:
- Port 2 only, 60-byte frame then delimiter, no stalls -> one header with port_id=2, length=60, err=0, header = first 14 bytes; 46 body writes; b_fifo_del concurrent with h_fifo_wren; stat_frames=1.
- All 4 ports continuously eligible, 8 frames -> grant order 0,1,2,3,0,1,2,3; rden is never high on two ports.
- Port 1 delivers 9 bytes then delimiter -> no h_fifo_wren, no b_fifo_del, stat_runts=1, 10 pops total.
- 1600-byte frame -> body writes stop at 1500; header length=1600, err=1; stat_oversize=1; all 1601 entries popped.
- i_fifo_empty toggling every other cycle mid-payload, and b_fifo_afull=1 during IDLE -> payload is byte-exact with no pops while empty; no grant until afull drops.
- arst pulsed mid-payload -> outputs 0 asynchronously; next grant goes to port 0; no header written for the aborted frame.
